// File: rtl/levitation_cmd_pkg.sv
// Shared constants, error codes and FSM state encoding for the levitation command parser.
package levitation_cmd_pkg;

    localparam logic [7:0] SOF       = 8'hFF;
    localparam logic [7:0] EOF       = 8'h3C;

    localparam logic [7:0] CMD_LEFT  = 8'h41;
    localparam logic [7:0] CMD_RIGHT = 8'h44;
    localparam logic [7:0] CMD_FWD   = 8'h57;
    localparam logic [7:0] CMD_BACK  = 8'h53;
    localparam logic [7:0] CMD_NOP   = 8'h4E;

    localparam logic [1:0] ERR_EOF     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_CMD     = 2'd2;
    localparam logic [1:0] ERR_CHK     = 2'd3;

    // ST_SUM is only reachable when the checksum byte is part of the frame.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CMD,
        ST_PHASE,
        ST_SUM
    } state_e;

    function automatic logic cmd_known(input logic [7:0] c);
        return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_FWD) ||
               (c == CMD_BACK) || (c == CMD_NOP);
    endfunction

endpackage

// File: rtl/levitation_cmd_timeout.sv
// Inter-byte timeout counter: clears on clr_i, counts while en_i, pulses expire_o at TIMEOUT_CYC-1.
module levitation_cmd_timeout #(
    parameter int TIMEOUT_CYC = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clearing byte in the same cycle always beats expiry.
    assign expire_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/levitation_cmd_parser.sv
// UART command-frame parser driving focus position and phase delay of the ultrasonic array.
// Define LEVITATION_CMD_CHECKSUM_EN for 5-byte frames carrying chk = cmd ^ phase.
module levitation_cmd_parser
    import levitation_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 250000,
    parameter int GRID_MAX    = 4,
    parameter int INIT_X      = 2,
    parameter int INIT_Y      = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_rdy_i,
    output logic [2:0] pos_x_o,
    output logic [2:0] pos_y_o,
    output logic [9:0] delay_o,
    output logic       cmd_valid_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o
);

    localparam logic [2:0] GMAX = 3'(GRID_MAX);

`ifdef LEVITATION_CMD_CHECKSUM_EN
    localparam state_e ST_LAST = ST_SUM;
`else
    localparam state_e ST_LAST = ST_PHASE;
`endif

    state_e     state_q;
    logic       rx_rdy_q;
    logic [7:0] cmd_q;
    logic [7:0] phase_q;
    logic [2:0] pos_x_q;
    logic [2:0] pos_y_q;
    logic [9:0] delay_q;
    logic       cmd_valid_q;
    logic       frame_err_q;
    logic [1:0] err_code_q;
    logic       busy_q;

    logic byte_stb;
    logic expire;
    logic chk_ok;

    assign byte_stb = rx_rdy_i & ~rx_rdy_q;

`ifdef LEVITATION_CMD_CHECKSUM_EN
    logic [7:0] chk_q;
    assign chk_ok = (chk_q == (cmd_q ^ phase_q));
`else
    assign chk_ok = 1'b1;
`endif

    levitation_cmd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (byte_stb | (state_q == ST_IDLE)),
        .en_i    (state_q != ST_IDLE),
        .expire_o(expire)
    );

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= GMAX) ? GMAX : v + 3'd1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rx_rdy_q    <= 1'b0;
            cmd_q       <= '0;
            phase_q     <= '0;
`ifdef LEVITATION_CMD_CHECKSUM_EN
            chk_q       <= '0;
`endif
            pos_x_q     <= 3'(INIT_X);
            pos_y_q     <= 3'(INIT_Y);
            delay_q     <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_EOF;
            busy_q      <= 1'b0;
        end else begin
            rx_rdy_q    <= rx_rdy_i;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (byte_stb) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data_i == SOF) begin
                            state_q <= ST_HDR;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_HDR: begin
                        cmd_q   <= rx_data_i;
                        state_q <= ST_CMD;
                    end
                    ST_CMD: begin
                        phase_q <= rx_data_i;
                        state_q <= ST_PHASE;
                    end
`ifdef LEVITATION_CMD_CHECKSUM_EN
                    ST_PHASE: begin
                        chk_q   <= rx_data_i;
                        state_q <= ST_SUM;
                    end
`endif
                    ST_LAST: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        // Error priority: framing, then command code, then checksum.
                        if (rx_data_i != EOF) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_EOF;
                        end else if (!cmd_known(cmd_q)) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CMD;
                        end else if (!chk_ok) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                        end else begin
                            cmd_valid_q <= 1'b1;
                            delay_q     <= {phase_q, 2'b00};
                            case (cmd_q)
                                CMD_LEFT:  pos_x_q <= sat_dec(pos_x_q);
                                CMD_RIGHT: pos_x_q <= sat_inc(pos_x_q);
                                CMD_FWD:   pos_y_q <= sat_dec(pos_y_q);
                                CMD_BACK:  pos_y_q <= sat_inc(pos_y_q);
                                default:   ;
                            endcase
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else if (expire) begin
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
            end
        end
    end

    assign pos_x_o     = pos_x_q;
    assign pos_y_o     = pos_y_q;
    assign delay_o     = delay_q;
    assign cmd_valid_o = cmd_valid_q;
    assign frame_err_o = frame_err_q;
    assign err_code_o  = err_code_q;
    assign busy_o      = busy_q;

endmodule
